sobel_magnitude: RTL
====================

# sobel_magnitude

Downstream stage of the 3x3 convolution engine in the Sobel pipeline. Consumes the signed horizontal and vertical gradients (Gx, Gy) for each pixel and produces an unsigned WIDTH_P-bit edge magnitude, |Gx| + |Gy|, saturated to the pixel range. It also zeroes the warm-up border pixels produced while the 3x3 window fills. Both sides use valid/ready handshakes, so the block can stall the convolution stage.

## Interface
- WIDTH_P, 8: output pixel width; gradient inputs are 2*WIDTH_P bits.
- DEPTH_P, 16: pixels per line (image width); must be >= 3.
- HEIGHT_P, 16: lines per frame; must be >= 3.

- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- valid_i  in  1  upstream gradient pair valid.
- ready_o  out  1  block can accept a gradient pair this cycle.
- gx_i  in  2*WIDTH_P  signed horizontal gradient.
- gy_i  in  2*WIDTH_P  signed vertical gradient.
- threshold_i  in  WIDTH_P  binarization threshold; used only with SOBEL_MAG_THRESH_EN.
- valid_o  out  1  output magnitude valid.
- ready_i  in  1  downstream can accept.
- data_o  out  WIDTH_P  edge magnitude.

## Operation
- Transfer in: valid_i && ready_o. Transfer out: valid_o && ready_i.
- Stage 1 registers |gx_i| and |gy_i| as 2*WIDTH_P-bit unsigned values. The most-negative input maps to 2^(2*WIDTH_P-1), with no overflow. Stage 1 also registers the border flag.
- Stage 2 computes the sum at 2*WIDTH_P+1 bits.
  - If the sum exceeds 2^WIDTH_P-1, the result is 2^WIDTH_P-1.
  - If the border flag is set, the result is 0.
  - The result is then registered to data_o.
- Position counters: col (0..DEPTH_P-1) and row (0..HEIGHT_P-1) advance only on an input transfer.
  - col wraps from DEPTH_P-1 to 0 and increments row.
  - row wraps from HEIGHT_P-1 to 0 (next frame).
- Border flag = (row < 2) || (col < 2), evaluated with the counter values *before* the increment for the accepted pixel.
- Pipeline advance rules:
  - Stage 2 loads when it is empty or ready_i is high.
  - Stage 1 loads when it is empty or stage 2 loads.
  - ready_o = stage 1 empty || stage 2 loads.
- No pixel is dropped or duplicated. Output order equals input order.
- data_o holds stable while valid_o && !ready_i.

## Timing
- Reset values:
  - valid_o=0, data_o=0, ready_o=1 (both stages empty).
  - col=0, row=0.
- Reset asserted mid-frame flushes both stages and restarts the counters at (0,0). Any data in flight is discarded.
- Latency: 2 cycles from input transfer to valid_o when not stalled. Throughput is 1 pixel/cycle with ready_i held high.
- Stall: with ready_i low, the block accepts at most 2 pixels (both stages fill), then ready_o goes low in the same cycle, combinationally from ready_i.
- Simultaneous events:
  - An output transfer and an input transfer in the same cycle keep the pipeline full without a bubble.
  - A counter wrap and a stall in the same cycle: the counters hold, because no transfer occurred.
- ready_o depends combinationally on ready_i. valid_o and data_o are registered.

## Configuration
- SOBEL_MAG_THRESH_EN defined:
  - Stage 2 outputs 2^WIDTH_P-1 when the saturated magnitude is >= threshold_i, else 0.
  - threshold_i is sampled when stage 2 loads.
  - Border pixels are still 0.
- Not defined: data_o is the saturated magnitude and threshold_i is ignored. Latency is identical in both builds.

## Test plan
All scenarios use WIDTH_P=8, DEPTH_P=16, HEIGHT_P=16.
- Reset: assert rst_i mid-stream -> valid_o=0 and data_o=0 immediately; ready_o=1 after release; the next pixel is treated as (row 0, col 0).
- Arithmetic, pixel at (row 5, col 5): gx_i=3, gy_i=-4 -> data_o=7 two cycles later. gx_i=-32768, gy_i=-32768 -> data_o=255. gx_i=200, gy_i=55 -> 255. gx_i=100, gy_i=-154 -> 254.
- Border: stream a full 16x16 frame with gx_i=gy_i=50 -> rows 0-1 and cols 0-1 output 0, all other pixels output 100. The second frame repeats the same pattern.
- Backpressure: continuous valid_i with an incrementing gradient, ready_i low for 5 cycles -> exactly 2 pixels are accepted, then ready_o=0 and data_o holds. After release the output sequence is gapless, in order and without duplicates.
- Random valid_i/ready_i at 50% each over 3 frames -> the output sequence matches the reference model and counter positions track accepted inputs only.
- With SOBEL_MAG_THRESH_EN, threshold_i=100 -> magnitude 99 outputs 0, magnitude 100 outputs 255, a border pixel with magnitude 200 outputs 0.

Source files
------------

// File: rtl/sobel_magnitude.sv
// Sobel edge magnitude: |Gx| + |Gy| saturated to WIDTH_P bits, warm-up border zeroed.
// Optional binarization against threshold_i when SOBEL_MAG_THRESH_EN is defined.
module sobel_magnitude #(
  parameter int WIDTH_P  = 8,
  parameter int DEPTH_P  = 16,
  parameter int HEIGHT_P = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [2*WIDTH_P-1:0]   gx_i,
  input  logic [2*WIDTH_P-1:0]   gy_i,
  input  logic [WIDTH_P-1:0]     threshold_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [WIDTH_P-1:0]     data_o
);

  localparam int GW = 2 * WIDTH_P;
  localparam int CW = $clog2(DEPTH_P);
  localparam int RW = $clog2(HEIGHT_P);

  // Two's-complement magnitude; the most-negative value lands on 2^(GW-1) unsigned.
  function automatic logic [GW-1:0] abs_f(input logic signed [GW-1:0] v);
    logic [GW-1:0] u;
    u = v;
    return u[GW-1] ? (~u + GW'(1)) : u;
  endfunction

  function automatic logic [WIDTH_P-1:0] sat_f(input logic [GW:0] s);
    return (|s[GW:WIDTH_P]) ? {WIDTH_P{1'b1}} : s[WIDTH_P-1:0];
  endfunction

  logic signed [GW-1:0] w_gx;
  logic signed [GW-1:0] w_gy;
  logic                 w_ld1;
  logic                 w_ld2;
  logic                 w_xfer_in;
  logic                 w_border;
  logic [GW:0]          w_sum;
  logic [WIDTH_P-1:0]   w_sat;
  logic [WIDTH_P-1:0]   w_res;

  logic                 r_vld_p1;
  logic [GW-1:0]        r_absx_p1;
  logic [GW-1:0]        r_absy_p1;
  logic                 r_border_p1;
  logic                 r_vld_p2;
  logic [WIDTH_P-1:0]   r_data_p2;
  logic [CW-1:0]        r_col;
  logic [RW-1:0]        r_row;

  assign w_gx      = gx_i;
  assign w_gy      = gy_i;
  assign w_ld2     = !r_vld_p2 || ready_i;
  assign w_ld1     = !r_vld_p1 || w_ld2;
  assign ready_o   = w_ld1;
  assign w_xfer_in = valid_i && w_ld1;
  assign w_border  = (r_row < RW'(2)) || (r_col < CW'(2));

  assign valid_o   = r_vld_p2;
  assign data_o    = r_data_p2;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_xfer_in) begin
      if (r_col == CW'(DEPTH_P - 1)) begin
        r_col <= '0;
        r_row <= (r_row == RW'(HEIGHT_P - 1)) ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Stage 1: absolute values and border flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vld_p1 <= 1'b0;
    end else if (w_ld1) begin
      r_vld_p1 <= valid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_xfer_in) begin
      r_absx_p1   <= abs_f(w_gx);
      r_absy_p1   <= abs_f(w_gy);
      r_border_p1 <= w_border;
    end
  end

  // Stage 2: sum, saturate, optional threshold, border blanking
  assign w_sum = {1'b0, r_absx_p1} + {1'b0, r_absy_p1};

  always_comb begin
    w_sat = sat_f(w_sum);
`ifdef SOBEL_MAG_THRESH_EN
    w_res = (w_sat >= threshold_i) ? {WIDTH_P{1'b1}} : '0;
`else
    w_res = w_sat;
`endif
    if (r_border_p1) begin
      w_res = '0;
    end
  end

`ifndef SOBEL_MAG_THRESH_EN
  logic w_unused_thresh;
  assign w_unused_thresh = ^threshold_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vld_p2  <= 1'b0;
      r_data_p2 <= '0;
    end else if (w_ld2) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_data_p2 <= w_res;
      end
    end
  end

endmodule
